// File: rtl/i2c_reg_target.sv
// Write-only I2C target: [dev addr+W] [reg addr] [data hi] [data lo], each byte ACKed,
// delivering each completed 16-bit register write as a one-cycle strobe.
module i2c_reg_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl,
    inout  wire         sda,
    output logic        wr_valid,
    output logic [7:0]  wr_reg_addr,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        abort
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA_HI, HI_ACK, DATA_LO, LO_ACK, IGNORE
    } state_t;

    // Pin conditioning: bit 0 = scl, bit 1 = sda. Flops reset high to match an idle bus.
    logic [1:0] pins;
    logic [1:0] sync_s;
    logic [1:0] prev_s;

    assign pins = {sda, scl};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg, s2_reg, prev_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_reg   <= 1'b1;
                    s2_reg   <= 1'b1;
                    prev_reg <= 1'b1;
                end else begin
                    s1_reg   <= pins[gi];
                    s2_reg   <= s1_reg;
                    prev_reg <= s2_reg;
                end
            end
            assign sync_s[gi] = s2_reg;
            assign prev_s[gi] = prev_reg;
        end
    endgenerate

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    assign scl_s     = sync_s[0];
    assign sda_s     = sync_s[1];
    assign scl_rise  = scl_s & ~prev_s[0];
    assign scl_fall  = ~scl_s & prev_s[0];
    assign start_det = scl_s & prev_s[1] & ~sda_s;
    assign stop_det  = scl_s & ~prev_s[1] & sda_s;

    state_t      state_reg, state_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  reg_addr_reg, reg_addr_next;
    logic [7:0]  data_hi_reg, data_hi_next;
    logic [7:0]  wr_reg_addr_next;
    logic [15:0] wr_data_next;
    logic        wr_valid_next, busy_next, abort_next;
    logic        sda_oe_reg, sda_oe_next;
    logic [7:0]  byte_val;

    assign byte_val = {shift_reg[6:0], sda_s};
    assign sda      = sda_oe_reg ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 4'd0;
            shift_reg    <= 8'd0;
            reg_addr_reg <= 8'd0;
            data_hi_reg  <= 8'd0;
            wr_reg_addr  <= 8'd0;
            wr_data      <= 16'd0;
            wr_valid     <= 1'b0;
            busy         <= 1'b0;
            abort        <= 1'b0;
            sda_oe_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            reg_addr_reg <= reg_addr_next;
            data_hi_reg  <= data_hi_next;
            wr_reg_addr  <= wr_reg_addr_next;
            wr_data      <= wr_data_next;
            wr_valid     <= wr_valid_next;
            busy         <= busy_next;
            abort        <= abort_next;
            sda_oe_reg   <= sda_oe_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        reg_addr_next    = reg_addr_reg;
        data_hi_next     = data_hi_reg;
        wr_reg_addr_next = wr_reg_addr;
        wr_data_next     = wr_data;
        wr_valid_next    = 1'b0;
        busy_next        = busy;
        abort_next       = 1'b0;
        sda_oe_next      = sda_oe_reg;

        // Bus conditions win over any SCL edge seen in the same cycle.
        if (start_det || stop_det) begin
            if (state_reg inside {ADDR_ACK, REG, REG_ACK, DATA_HI, HI_ACK, DATA_LO})
                abort_next = 1'b1;
            busy_next    = 1'b0;
            sda_oe_next  = 1'b0;
            bit_cnt_next = 4'd0;
            shift_next   = 8'd0;
            state_next   = start_det ? ADDR : IDLE;
        end else begin
            case (state_reg)
                ADDR, REG, DATA_HI, DATA_LO: begin
                    if (scl_rise) begin
                        shift_next   = byte_val;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next = 4'd0;
                            case (state_reg)
                                ADDR: begin
                                    if (byte_val[7:1] == DEV_ADDR && !byte_val[0]) begin
                                        state_next = ADDR_ACK;
                                        busy_next  = 1'b1;
                                    end else begin
                                        state_next = IGNORE;
                                    end
                                end
                                REG: begin
                                    reg_addr_next = byte_val;
                                    state_next    = REG_ACK;
                                end
                                DATA_HI: begin
                                    data_hi_next = byte_val;
                                    state_next   = HI_ACK;
                                end
                                default: begin
                                    wr_valid_next    = 1'b1;
                                    wr_reg_addr_next = reg_addr_reg;
                                    wr_data_next     = {data_hi_reg, byte_val};
                                    state_next       = LO_ACK;
                                end
                            endcase
                        end
                    end
                end
                // First fall (end of bit 7) drives ACK; second fall (end of 9th clock) releases.
                ADDR_ACK, REG_ACK, HI_ACK, LO_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_reg) begin
                            sda_oe_next = 1'b1;
                        end else begin
                            sda_oe_next = 1'b0;
                            case (state_reg)
                                ADDR_ACK: state_next = REG;
                                REG_ACK:  state_next = DATA_HI;
                                HI_ACK:   state_next = DATA_LO;
                                default:  state_next = IGNORE;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/i2c_reg_target.md
# i2c_reg_target

I2C target (slave) that receives register-write transactions on the audio-codec control bus and presents each completed write as a one-cycle strobe. Frame format: 7-bit device address with the write bit, an 8-bit register address, then a 16-bit data word sent MSB first, with each byte acknowledged. It sits behind the board I2C pins and lets FPGA-side logic act as a configurable peripheral, or stand in as a loopback target for master testing. It supports writes only. All SCL/SDA handling is oversampled on the system clock.

## Interface
- DEV_ADDR, 7'h1A: 7-bit address this target answers to.
- clk  input  1  system clock (50 MHz); must be ≥16× the SCL rate.
- reset_n  input  1  asynchronous, active-low reset.
- scl  input  1  I2C clock from the master; not driven.
- sda  inout  1  I2C data line, open-drain. The block drives only 0 (when sda_oe=1), otherwise high-Z.
- wr_valid  output  1  one-cycle strobe: a full 16-bit write was received.
- wr_reg_addr  output  8  register address of the last write; held until the next write.
- wr_data  output  16  data of the last write; held until the next write.
- busy  output  1  high from address match until STOP, START, or abort.
- abort  output  1  one-cycle strobe: an addressed transfer ended before its 16-bit word completed.

## Operation
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer.
  - A third flop holds the previous synced value for edge detection.
  - All decisions use the synced values only.
- Bus events:
  - START: synced sda falls while synced scl is high.
  - STOP: synced sda rises while synced scl is high.
  - SCL rise / SCL fall: edges of synced scl.
- Bit handling:
  - Data bits are shifted in MSB first on SCL rise.
  - A 4-bit counter counts bits 0..7 of each byte.
- ACK handling:
  - On the SCL fall that ends bit 7, the block sets sda_oe=1 if an ACK is due.
  - On the next SCL fall (end of the 9th clock), sda_oe is cleared.
- State machine:
  - IDLE: wait for START, which goes to ADDR.
  - ADDR: after 8 bits:
    - If byte[7:1]==DEV_ADDR and byte[0]==0, go to ADDR_ACK.
    - Otherwise (wrong address, or read request) go to IGNORE with no ACK.
  - ADDR_ACK → REG; busy is set on entry.
  - REG: after 8 bits, latch the register address internally, then go to REG_ACK → DATA_HI.
  - DATA_HI: after 8 bits, go to HI_ACK → DATA_LO.
  - DATA_LO: on the 8th SCL rise:
    - Commit wr_reg_addr, wr_data={hi,lo}, and wr_valid=1 in the next clk.
    - Go to LO_ACK → IGNORE.
  - IGNORE:
    - sda_oe stays 0, so any further bytes are NACKed.
    - busy stays high only if this transaction was addressed.
- Bus events in any state:
  - START from any state (repeated start) goes to ADDR.
  - STOP from any state goes to IDLE.
- abort:
  - Pulses for one clk when START or STOP arrives in ADDR_ACK..DATA_LO (before the commit).
  - In the same cycle busy clears and sda_oe clears.
- A START/STOP detected in the same clk as an SCL edge takes priority; that edge is discarded.

## Timing
- Reset values: wr_valid=0, wr_reg_addr=0, wr_data=0, busy=0, abort=0, sda_oe=0 (sda high-Z), state IDLE, shift register and counters zero.
- Reset is asynchronous: asserting reset_n mid-transfer releases sda in the same cycle, without waiting for a clock edge.
- Input latency: a pin edge is acted on 3 clk after it occurs (2 synchronizer flops + 1 edge flop).
- ACK drive:
  - sda_oe asserts in the clk after the SCL fall is detected.
  - This leaves ≥ a quarter SCL period of setup before the master's 9th SCL rise.
- wr_valid: exactly 1 clk, asserted 1 clk after the detected SCL rise of bit 0 of the low data byte. wr_reg_addr and wr_data are valid in the same cycle.
- busy:
  - Rises 1 clk after the detected 8th address-bit rise on a match.
  - Falls 1 clk after a detected STOP or START.
- The block never drives scl, so it does no clock stretching.

## Test plan
- Write 0x34, 0x0F, 0x12, 0x34, then STOP → ACK low on all four 9th clocks; exactly one wr_valid with wr_reg_addr=0x0F, wr_data=0x1234; busy falls after STOP; abort=0.
- Address 0x36 (DEV_ADDR=0x1A) followed by 3 bytes → sda never driven; no wr_valid; busy stays 0.
- Address 0x35 (read bit set) → NACK on address; IGNORE state; no outputs change.
- 0x34, 0x0F, then STOP → ACKs on 2 bytes; abort pulses once; wr_valid stays 0; wr_data keeps its previous value.
- Full write, then a 5th byte 0xAA, then STOP → 5th byte NACKed; only one wr_valid; then a repeated START plus a new full write to reg 0x10, data 0xBEEF → second wr_valid with those values.
- reset_n asserted low during an ACK bit → sda released immediately; all outputs at reset values; a subsequent full write succeeds normally.
